conv_encoder_framer: RTL and testbench
======================================

// Module: conv_encoder_framer
// PURPOSE
//  Rate-1/2, K=4 (8-state) convolutional encoder feeding the Viterbi decoder's d_in[1:0]/enable.
//  Buffers serial payload bits in a small FIFO, emits one 2-bit code symbol per accepted beat,
//  appends K-1=3 zero tail bits per frame so the trellis terminates in state 000.
// PARAMETERS
//  FRAME_LEN   1024     payload bits per frame (excl. tail); >=1
//  FIFO_DEPTH  8        input FIFO entries; power of 2, >=2
//  G0          4'b1101  generator for enc_out[0], taps on v={din,sr[2],sr[1],sr[0]}
//  G1          4'b1111  generator for enc_out[1], same tap vector
// PORTS
//  clk         in   1  rising-edge clock (single clock domain)
//  rst         in   1  asynchronous, active-low reset
//  start       in   1  1-cycle pulse: begin a frame (honoured only in IDLE)
//  in_data     in   1  payload bit
//  in_valid    in   1  in_data valid
//  in_ready    out  1  FIFO can accept; push = in_valid & in_ready
//  out_ready   in   1  downstream accepts enc_out this cycle
//  enc_out     out  2  code symbol {c1,c0}; connects to decoder d_in
//  enc_valid   out  1  enc_out valid; connects to decoder enable
//  busy        out  1  state != IDLE
//  frame_done  out  1  1-cycle pulse after last tail symbol is accepted
//  underrun    out  1  sticky: FIFO empty while a DATA symbol was due; cleared by honoured start
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, FIFO empty, sr=000, bit_cnt=0, enc_out=00, enc_valid=0,
//   in_ready=0 while rst=0 then 1, busy=0, frame_done=0, underrun=0. Mid-frame reset drops all data.
//  FIFO: push in any state; in_ready = !full (no push when full, even with same-cycle pop).
//   No bypass: a bit pushed at cycle t is poppable at t+1 at earliest.
//  Output register: loads when slot free = (!enc_valid | out_ready); else enc_out/enc_valid held.
//  Encoder math: v={din,sr[2],sr[1],sr[0]}; c0=^(v&G0); c1=^(v&G1); on load sr <= {din,sr[2:1]}.
//  FSM (bit_cnt width $clog2(FRAME_LEN+1)):
//   IDLE: start=1 -> DATA; sr<=000, bit_cnt<=0, underrun<=0. start in DATA/TAIL ignored.
//   DATA: slot free & FIFO non-empty -> pop, load symbol, enc_valid<=1, bit_cnt++;
//         on FRAME_LEN-th load -> TAIL, bit_cnt<=0.
//         slot free & FIFO empty -> enc_valid<=0, underrun<=1, state/sr/bit_cnt held (stall).
//   TAIL: slot free -> load symbol with din=0 (no pop), bit_cnt++; after 3rd load -> DRAIN.
//   DRAIN: wait for last tail symbol accepted (enc_valid & out_ready) -> enc_valid<=0,
//          frame_done=1 that cycle+1 (registered), -> IDLE. sr is 000 on exit.
//   Slot free in IDLE -> enc_valid<=0.
//  Latency: start@t with FIFO non-empty -> first enc_valid@t+2; symbol rate 1/cycle with out_ready=1.
//  Continuous enable to the decoder requires out_ready=1 and no underrun; bits buffered before start
//   are consumed first. Payload bits arriving after frame end remain in FIFO for the next frame.
//  Simultaneous start and frame_done: start sampled only when state==IDLE (not in DRAIN).
// TESTING
//  1 Reset: rst=0 mid-TAIL -> all outputs at reset values immediately; after release in_ready=1, busy=0.
//  2 FRAME_LEN=4, push 1,0,1,1, start, out_ready=1 -> enc_out 11,11,01,11 then tail 01,01,11;
//    7 contiguous enc_valid cycles, frame_done pulse once, busy falls.
//  3 Same frame, out_ready=0 for 3 cycles after 2nd symbol -> enc_out held at 11, sequence
//    unchanged, no symbol lost or duplicated.
//  4 Push 2 bits, start, FRAME_LEN=4 -> enc_valid drops after 2 symbols, underrun=1; push 2 more ->
//    resume with correct symbols; underrun stays 1 until next start.
//  5 FIFO_DEPTH=8, in_valid held with no start -> 8 pushes, in_ready=0 on 9th; start -> in_ready
//    returns 1 after first pop, FIFO order preserved.
//  6 start pulsed during DATA and TAIL -> ignored; back-to-back frames -> sr restarts at 000, frame 2
//    encodes identically to frame 1 for identical payload.

Source files
------------

// File: rtl/conv_encoder_framer.sv
// Rate-1/2, K=4 convolutional encoder with input FIFO and frame framing.
// Payload bits are buffered in a small FIFO and encoded one per accepted
// output beat. Three zero tail bits are appended per frame so the
// trellis always ends in state 000.
module conv_encoder_framer #(
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [3:0]  G0         = 4'b1101,
    parameter logic [3:0]  G1         = 4'b1111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic [1:0] enc_out,
    output logic       enc_valid,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = $clog2(FRAME_LEN + 1);
    // The tail phase reuses the bit counter and must reach 2.
    localparam int unsigned CNTW = (CW < 2) ? 2 : CW;

    localparam logic [AW:0]     PTR_ONE  = (AW + 1)'(1);
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(FRAME_LEN - 1);
    localparam logic [CNTW-1:0] TAIL_LAST = CNTW'(2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_TAIL  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // ------------------------------------------------------------------
    // Input FIFO (pointers carry one extra wrap bit)
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0] mem_q;
    logic [AW:0]           wr_ptr_q;
    logic [AW:0]           rd_ptr_q;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_head;
    logic                  push;
    logic                  pop;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
    // Full blocks a push even if the FSM pops in the same cycle.
    assign push       = in_valid & ~fifo_full;
    assign in_ready   = rst & ~fifo_full;

    // FIFO storage and pointer update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= in_data;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Framing FSM, encoder shift register and output register
    // ------------------------------------------------------------------
    logic [1:0]      state_q,     state_d;
    logic [2:0]      sr_q,        sr_d;
    logic [CNTW-1:0] cnt_q,       cnt_d;
    logic [1:0]      enc_out_q,   enc_out_d;
    logic            enc_valid_q, enc_valid_d;
    logic            underrun_q,  underrun_d;
    logic            done_q,      done_d;

    logic            slot_free;
    logic            din;
    logic [3:0]      tap_vec;
    logic [1:0]      symbol;
    logic            load;

    assign slot_free = ~enc_valid_q | out_ready;
    // Tail symbols are encoded with a zero input bit.
    assign din       = (state_q == S_DATA) ? fifo_head : 1'b0;
    assign tap_vec   = {din, sr_q};
    assign symbol    = {^(tap_vec & G1), ^(tap_vec & G0)};

    // Next-state logic for the frame sequencer and output slot
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        enc_out_d   = enc_out_q;
        enc_valid_d = enc_valid_q;
        underrun_d  = underrun_q;
        done_d      = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (slot_free) begin
                    enc_valid_d = 1'b0;
                end
                if (start) begin
                    state_d    = S_DATA;
                    sr_d       = '0;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            S_DATA: begin
                if (slot_free) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                        if (cnt_q == CNT_LAST) begin
                            state_d = S_TAIL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else begin
                        enc_valid_d = 1'b0;
                        underrun_d  = 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    load = 1'b1;
                    if (cnt_q == TAIL_LAST) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                if (enc_valid_q && out_ready) begin
                    enc_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase

        if (load) begin
            enc_out_d   = symbol;
            enc_valid_d = 1'b1;
            sr_d        = {din, sr_q[2:1]};
        end
    end

    // Register the sequencer state and outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            enc_out_q   <= '0;
            enc_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            enc_out_q   <= enc_out_d;
            enc_valid_q <= enc_valid_d;
            underrun_q  <= underrun_d;
            done_q      <= done_d;
        end
    end

    assign enc_out    = enc_out_q;
    assign enc_valid  = enc_valid_q;
    assign busy       = (state_q != S_IDLE);
    assign frame_done = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_conv_encoder_framer.sv
// Directed bench for conv_encoder_framer with FRAME_LEN=4, FIFO_DEPTH=8.
// Expected code symbols are hand-computed from G0=1101, G1=1111.
module tb_conv_encoder_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       in_data = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic [1:0] enc_out;
    logic       enc_valid;
    logic       busy;
    logic       frame_done;
    logic       underrun;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] got[$];
    logic [1:0] exp_q[$];

    int firstv;
    int vcyc;

    always #5 clk = ~clk;

    conv_encoder_framer #(
        .FRAME_LEN (4),
        .FIFO_DEPTH(8),
        .G0        (4'b1101),
        .G1        (4'b1111)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .enc_out   (enc_out),
        .enc_valid (enc_valid),
        .busy      (busy),
        .frame_done(frame_done),
        .underrun  (underrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push n bits, LSB of bits first.
    task automatic push_bits(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = bits[i];
            chk($sformatf("push_rdy%0d", i), in_ready, 1);
            step();
        end
        in_valid = 1'b0;
    endtask

    // Collect accepted symbols until frame_done; optional start pulses and
    // an out_ready stall of stall_len cycles once stall_at symbols are taken.
    task automatic drain(input logic [31:0] smask, input int stall_at, input int stall_len,
                         output int first_valid, output int valid_cycles);
        int   acc = 0;
        int   stall = 0;
        logic hold = 1'b0;
        logic [1:0] held = 2'b00;
        logic seen = 1'b0;
        got.delete();
        first_valid  = -1;
        valid_cycles = 0;
        for (int c = 0; c < 60 && !seen; c++) begin
            start     = (c < 32) ? smask[c] : 1'b0;
            out_ready = !(acc == stall_at && stall < stall_len);
            if (frame_done) begin
                seen = 1'b1;
            end else begin
                if (hold) begin
                    chk("hold_valid", enc_valid, 1);
                    chk("hold_sym", enc_out, held);
                end
                hold = enc_valid && !out_ready;
                held = enc_out;
                if (!out_ready) stall++;
                if (enc_valid) begin
                    valid_cycles++;
                    if (first_valid < 0) first_valid = c;
                    if (out_ready) begin
                        got.push_back(enc_out);
                        acc++;
                    end
                end
                step();
            end
        end
        start     = 1'b0;
        out_ready = 1'b1;
        chk("fd_seen", seen, 1);
        chk("fd_idle", busy, 0);
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s_sym%0d", tag, i), got[i], exp_q[i]);
        end
    endtask

    initial begin
        // Reset values while rst is held low
        #2;
        chk("rst_valid", enc_valid, 0);
        chk("rst_out", enc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fd", frame_done, 0);
        chk("rst_udr", underrun, 0);
        chk("rst_rdy", in_ready, 0);
        step();
        rst = 1'b1;
        step();
        chk("post_rst_rdy", in_ready, 1);
        chk("post_rst_busy", busy, 0);

        // Basic frame: payload 1,0,1,1
        push_bits(8'h0D, 4);
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("f1_busy", busy, 1);
        chk("f1_lat0", enc_valid, 0);
        drain(32'h0, -1, 0, firstv, vcyc);
        exp_q = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
        cmp_seq("f1");
        chk("f1_first", firstv, 1);
        chk("f1_vcyc", vcyc, 7);
        step();
        chk("f1_fd_pulse", frame_done, 0);

        // Same frame with a 3-cycle backpressure while symbol 2 is shown
        push_bits(8'h0D, 4);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(32'h0, 1, 3, firstv, vcyc);
        cmp_seq("bp");
        chk("bp_vcyc", vcyc, 10);
        step();
        chk("bp_fd_pulse", frame_done, 0);

        // Underrun: only 2 bits before start, rest arrive later
        push_bits(8'h01, 2);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ur_lat0", enc_valid, 0);
        step();
        chk("ur_s1", enc_out, 2'b11);
        chk("ur_v1", enc_valid, 1);
        step();
        chk("ur_s2", enc_out, 2'b11);
        step();
        chk("ur_gap", enc_valid, 0);
        chk("ur_flag", underrun, 1);
        in_valid = 1'b1;
        in_data  = 1'b1;
        chk("ur_push_rdy", in_ready, 1);
        step();
        chk("ur_nobypass", enc_valid, 0);
        step();
        in_valid = 1'b0;
        drain(32'h0, -1, 0, firstv, vcyc);
        exp_q = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
        cmp_seq("ur");
        chk("ur_sticky", underrun, 1);
        step();
        chk("ur_sticky2", underrun, 1);

        // FIFO fill with no start, then two frames in push order
        push_bits(8'h6D, 8);
        chk("full_rdy", in_ready, 0);
        in_valid = 1'b1;
        in_data  = 1'b1;
        step();
        in_valid = 1'b0;
        chk("full_hold", in_ready, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ff_udr_clr", underrun, 0);
        chk("ff_rdy_nopop", in_ready, 0);
        step();
        chk("ff_rdy_pop", in_ready, 1);
        drain(32'h0, -1, 0, firstv, vcyc);
        exp_q = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
        cmp_seq("ffa");
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        drain(32'h0, -1, 0, firstv, vcyc);
        exp_q = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};
        cmp_seq("ffb");
        step();

        // Start ignored in DATA/TAIL/DRAIN; back-to-back identical frames
        push_bits(8'hDD, 8);
        start = 1'b1;
        step();
        start = 1'b0;
        drain(32'hA2, -1, 0, firstv, vcyc);
        exp_q = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
        cmp_seq("ig");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b_fd_pulse", frame_done, 0);
        chk("b2b_busy", busy, 1);
        drain(32'h0, -1, 0, firstv, vcyc);
        cmp_seq("b2b");
        step();
        chk("b2b_idle", busy, 0);

        // Reset asserted mid-TAIL drops everything, including buffered bits
        push_bits(8'h6D, 8);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("mr_busy_pre", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("mr_valid", enc_valid, 0);
        chk("mr_out", enc_out, 0);
        chk("mr_busy", busy, 0);
        chk("mr_fd", frame_done, 0);
        chk("mr_udr", underrun, 0);
        chk("mr_rdy", in_ready, 0);
        step();
        rst = 1'b1;
        step();
        chk("mr_rdy_rel", in_ready, 1);
        chk("mr_busy_rel", busy, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("mr_dropped", enc_valid, 0);
        chk("mr_dropped_udr", underrun, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
